// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU/loader request ports and data-memory port of the dmem arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_exception;

    logic              ldr_req;
    logic              ldr_we;
    logic [31:0]       ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [3:0]        ldr_be;
    logic              ldr_ready;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_error;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic [31:0]       perf_cpu_stall;
    logic [31:0]       perf_ldr_xfer;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_exception,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be,
        output ldr_ready, ldr_rvalid, ldr_rdata, ldr_error,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata,
        output perf_cpu_stall, perf_ldr_xfer
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_exception,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be,
        input  ldr_ready, ldr_rvalid, ldr_rdata, ldr_error,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata,
        input  perf_cpu_stall, perf_ldr_xfer
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data-memory arbiter with loader starvation guard
// Optional perf counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    logic [CNT_W-1:0]  starve_cnt;
    logic              rd_pending;
    logic              rd_owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;

    logic              ldr_grant;
    logic              cpu_grant;
    logic              grant;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_be;
    logic              in_range;
    logic              accept;
    logic              rd_accept;
    logic              cpu_rvalid;
    logic              ldr_rvalid;

    // Reset gates every grant so a request during reset is never acknowledged.
    always_comb begin
        ldr_grant = !reset && bus.ldr_req && (!bus.cpu_req || starve_cnt == LIMIT);
        cpu_grant = !reset && bus.cpu_req && !ldr_grant;
        grant     = ldr_grant || cpu_grant;
        sel_we    = ldr_grant ? bus.ldr_we    : bus.cpu_we;
        sel_addr  = ldr_grant ? bus.ldr_addr  : bus.cpu_addr;
        sel_wdata = ldr_grant ? bus.ldr_wdata : bus.cpu_wdata;
        sel_be    = ldr_grant ? bus.ldr_be    : bus.cpu_be;
        in_range  = (sel_addr[31:ADDR_W] == '0);
        accept    = grant && in_range;
        rd_accept = accept && !sel_we;
        cpu_rvalid = !reset && rd_pending && (rd_owner == OWNER_CPU);
        ldr_rvalid = !reset && rd_pending && (rd_owner == OWNER_LDR);
    end

    assign bus.cpu_ready     = cpu_grant;
    assign bus.ldr_ready     = ldr_grant;
    assign bus.cpu_exception = cpu_grant && !in_range;
    assign bus.ldr_error     = ldr_grant && !in_range;
    assign bus.cpu_rvalid    = cpu_rvalid;
    assign bus.ldr_rvalid    = ldr_rvalid;

    assign bus.mem_en    = accept;
    assign bus.mem_we    = accept && sel_we;
    assign bus.mem_addr  = reset ? '0 : (grant ? sel_addr[ADDR_W-1:0] : addr_q);
    assign bus.mem_wdata = reset ? '0 : (grant ? sel_wdata : wdata_q);
    assign bus.mem_be    = reset ? '0 : (grant ? sel_be : be_q);

    // Read data passes straight through in the return cycle, then is held for the owner.
    assign bus.cpu_rdata = reset ? '0 : (cpu_rvalid ? bus.mem_rdata : cpu_rdata_q);
    assign bus.ldr_rdata = reset ? '0 : (ldr_rvalid ? bus.mem_rdata : ldr_rdata_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= '0;
            rd_pending  <= 1'b0;
            rd_owner    <= OWNER_CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            if (!bus.ldr_req || ldr_grant) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            rd_pending <= rd_accept;
            if (rd_accept) begin
                rd_owner <= ldr_grant ? OWNER_LDR : OWNER_CPU;
            end
            if (grant) begin
                addr_q  <= sel_addr[ADDR_W-1:0];
                wdata_q <= sel_wdata;
                be_q    <= sel_be;
            end
            if (cpu_rvalid) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
            if (ldr_rvalid) begin
                ldr_rdata_q <= bus.mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] xfer_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (bus.cpu_req && !cpu_grant) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (accept && ldr_grant) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_cpu_stall = stall_cnt;
    assign bus.perf_ldr_xfer  = xfer_cnt;
`else
    assign bus.perf_cpu_stall = '0;
    assign bus.perf_ldr_xfer  = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(10), .STARVE_LIMIT(8), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem [256] = '{1: 32'hC0FFEE01, 2: 32'h0BADF00D, 4: 32'hDEADBEEF, default: 32'h5A5A5A5A};
    logic [31:0] ref_mem [256] = '{1: 32'hC0FFEE01, 2: 32'h0BADF00D, 4: 32'hDEADBEEF, default: 32'h5A5A5A5A};

    always @(posedge clk) begin
        if (reset) begin
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr[9:2]];
            end
        end
    end

    typedef struct {
        bit          ldr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic set_idle();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0; bus.ldr_be = '0;
    endtask

    task automatic drive_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_be = be;
    endtask

    task automatic drive_ldr(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        bus.ldr_req = 1; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wd; bus.ldr_be = be;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        drive_cpu(0, 32'h10, 32'h0, 4'hF);
        drive_ldr(1, 32'h8, 32'h1111_2222, 4'hF);
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_cpu_ready got %b want 0", bus.cpu_ready); end
        tests_run++; if (bus.ldr_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ldr_ready got %b want 0", bus.ldr_ready); end
        tests_run++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_en_we got %b%b want 00", bus.mem_en, bus.mem_we); end
        tests_run++; if (bus.mem_addr !== 10'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin tests_failed++; $display("FAIL rst_mem_bus got %h/%h/%h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        tests_run++; if (bus.cpu_rdata !== 32'h0 || bus.ldr_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata got %h/%h want 0", bus.cpu_rdata, bus.ldr_rdata); end
        tests_run++; if (bus.cpu_rvalid !== 1'b0 || bus.ldr_rvalid !== 1'b0 || bus.cpu_exception !== 1'b0 || bus.ldr_error !== 1'b0) begin tests_failed++; $display("FAIL rst_flags got %b%b%b%b want 0000", bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_exception, bus.ldr_error); end
        @(negedge clk);
        set_idle();
        reset = 0;
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        drive_cpu(0, 32'h0000_0010, 32'h0, 4'hF);
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b1 || bus.ldr_ready !== 1'b0) begin tests_failed++; $display("FAIL cpu_rd_ready got %b/%b want 1/0", bus.cpu_ready, bus.ldr_ready); end
        tests_run++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'h010) begin tests_failed++; $display("FAIL cpu_rd_mem got en=%b we=%b addr=%h want 1/0/010", bus.mem_en, bus.mem_we, bus.mem_addr); end
        sb.push_back('{ldr: 1'b0, data: ref_mem[4]});
        @(negedge clk);
        set_idle();
        #1;
        tests_run++;
        if (sb.size() == 0) begin tests_failed++; $display("FAIL cpu_rd_sb empty"); end
        else begin
            e = sb.pop_front();
            if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e.data) begin tests_failed++; $display("FAIL cpu_rd_data got v=%b %h want 1 %h", bus.cpu_rvalid, bus.cpu_rdata, e.data); end
        end
        tests_run++; if (bus.ldr_rvalid !== 1'b0) begin tests_failed++; $display("FAIL cpu_rd_cross got ldr_rvalid=%b want 0", bus.ldr_rvalid); end
        tests_run++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'h010) begin tests_failed++; $display("FAIL idle_hold got en=%b we=%b addr=%h want 0/0/010", bus.mem_en, bus.mem_we, bus.mem_addr); end
    endtask

    task automatic test_ldr_write();
        @(negedge clk);
        drive_ldr(1, 32'h0000_03FC, 32'h1234_5678, 4'hF);
        #1;
        tests_run++; if (bus.ldr_ready !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin tests_failed++; $display("FAIL ldr_wr_ctl got rdy=%b en=%b we=%b want 111", bus.ldr_ready, bus.mem_en, bus.mem_we); end
        tests_run++; if (bus.mem_addr !== 10'h3FC || bus.mem_wdata !== 32'h1234_5678 || bus.mem_be !== 4'hF) begin tests_failed++; $display("FAIL ldr_wr_bus got %h/%h/%h want 3fc/12345678/f", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        ref_mem[255] = 32'h1234_5678;
        @(negedge clk);
        set_idle();
        #1;
        tests_run++; if (bus.ldr_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL ldr_wr_norvalid got %b/%b want 0/0", bus.ldr_rvalid, bus.cpu_rvalid); end
        @(negedge clk);
        drive_cpu(0, 32'h0000_03FC, 32'h0, 4'hF);
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b1) begin tests_failed++; $display("FAIL readback_ready got %b want 1", bus.cpu_ready); end
        sb.push_back('{ldr: 1'b0, data: ref_mem[255]});
        @(negedge clk);
        set_idle();
        #1;
        tests_run++;
        if (sb.size() == 0) begin tests_failed++; $display("FAIL readback_sb empty"); end
        else begin
            e = sb.pop_front();
            if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e.data) begin tests_failed++; $display("FAIL readback_data got v=%b %h want 1 %h", bus.cpu_rvalid, bus.cpu_rdata, e.data); end
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        drive_cpu(0, 32'h0000_0400, 32'h0, 4'hF);
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b1 || bus.cpu_exception !== 1'b1 || bus.mem_en !== 1'b0) begin tests_failed++; $display("FAIL cpu_oor got rdy=%b exc=%b en=%b want 1/1/0", bus.cpu_ready, bus.cpu_exception, bus.mem_en); end
        @(negedge clk);
        set_idle();
        #1;
        tests_run++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_exception !== 1'b0) begin tests_failed++; $display("FAIL cpu_oor_after got rv=%b exc=%b want 0/0", bus.cpu_rvalid, bus.cpu_exception); end
        @(negedge clk);
        drive_ldr(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
        #1;
        tests_run++; if (bus.ldr_ready !== 1'b1 || bus.ldr_error !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL ldr_oor got rdy=%b err=%b en=%b we=%b want 1/1/0/0", bus.ldr_ready, bus.ldr_error, bus.mem_en, bus.mem_we); end
        @(negedge clk);
        set_idle();
        #1;
        tests_run++; if (bus.ldr_rvalid !== 1'b0 || bus.ldr_error !== 1'b0) begin tests_failed++; $display("FAIL ldr_oor_after got rv=%b err=%b want 0/0", bus.ldr_rvalid, bus.ldr_error); end
    endtask

    task automatic test_interleaved();
        logic [31:0] cpu_word;
        @(negedge clk);
        drive_cpu(0, 32'h0000_0004, 32'h0, 4'hF);
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b1) begin tests_failed++; $display("FAIL il_cpu_ready got %b want 1", bus.cpu_ready); end
        cpu_word = ref_mem[1];
        sb.push_back('{ldr: 1'b0, data: cpu_word});
        @(negedge clk);
        set_idle();
        drive_ldr(0, 32'h0000_0008, 32'h0, 4'hF);
        #1;
        tests_run++;
        if (sb.size() == 0) begin tests_failed++; $display("FAIL il_cpu_sb empty"); end
        else begin
            e = sb.pop_front();
            if (e.ldr || bus.cpu_rvalid !== 1'b1 || bus.ldr_rvalid !== 1'b0 || bus.cpu_rdata !== e.data) begin tests_failed++; $display("FAIL il_cpu_data got cv=%b lv=%b %h want 1/0 %h", bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_rdata, e.data); end
        end
        tests_run++; if (bus.ldr_ready !== 1'b1 || bus.mem_addr !== 10'h008) begin tests_failed++; $display("FAIL il_ldr_grant got rdy=%b addr=%h want 1/008", bus.ldr_ready, bus.mem_addr); end
        sb.push_back('{ldr: 1'b1, data: ref_mem[2]});
        @(negedge clk);
        set_idle();
        #1;
        tests_run++;
        if (sb.size() == 0) begin tests_failed++; $display("FAIL il_ldr_sb empty"); end
        else begin
            e = sb.pop_front();
            if (!e.ldr || bus.ldr_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0 || bus.ldr_rdata !== e.data) begin tests_failed++; $display("FAIL il_ldr_data got lv=%b cv=%b %h want 1/0 %h", bus.ldr_rvalid, bus.cpu_rvalid, bus.ldr_rdata, e.data); end
        end
        tests_run++; if (bus.cpu_rdata !== cpu_word) begin tests_failed++; $display("FAIL il_cpu_hold got %h want %h", bus.cpu_rdata, cpu_word); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        addrs = '{32'h10, 32'h4, 32'h8, 32'h3FC};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                tests_run++;
                if (sb.size() == 0) begin tests_failed++; $display("FAIL b2b_sb empty at %0d", i); end
                else begin
                    e = sb.pop_front();
                    if (e.ldr ? (bus.ldr_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0 || bus.ldr_rdata !== e.data)
                              : (bus.cpu_rvalid !== 1'b1 || bus.ldr_rvalid !== 1'b0 || bus.cpu_rdata !== e.data)) begin
                        tests_failed++;
                        $display("FAIL b2b_data[%0d] got cv=%b lv=%b c=%h l=%h want owner=%0d %h", i, bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_rdata, bus.ldr_rdata, e.ldr, e.data);
                    end
                end
            end
            set_idle();
            if (i < 4) begin
                if (i % 2 == 0) drive_cpu(0, addrs[i], 32'h0, 4'hF);
                else            drive_ldr(0, addrs[i], 32'h0, 4'hF);
                #1;
                tests_run++;
                if ((i % 2 == 0 ? bus.cpu_ready : bus.ldr_ready) !== 1'b1 || bus.mem_en !== 1'b1) begin tests_failed++; $display("FAIL b2b_grant[%0d] got c=%b l=%b en=%b want grant", i, bus.cpu_ready, bus.ldr_ready, bus.mem_en); end
                sb.push_back('{ldr: (i % 2 == 1), data: ref_mem[addrs[i][9:2]]});
            end
        end
    endtask

    task automatic test_starvation();
        int          m = 0;
        int          stalls = 0;
        int          first_ldr = -1;
        bit          exp_ldr;
        logic [31:0] perf0;
        perf0 = bus.perf_cpu_stall;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc > 0) begin
                tests_run++;
                if (sb.size() == 0) begin tests_failed++; $display("FAIL starve_sb empty at %0d", cyc); end
                else begin
                    e = sb.pop_front();
                    if (e.ldr ? (bus.ldr_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0 || bus.ldr_rdata !== e.data)
                              : (bus.cpu_rvalid !== 1'b1 || bus.ldr_rvalid !== 1'b0 || bus.cpu_rdata !== e.data)) begin
                        tests_failed++;
                        $display("FAIL starve_rdata[%0d] got cv=%b lv=%b want owner=%0d %h", cyc, bus.cpu_rvalid, bus.ldr_rvalid, e.ldr, e.data);
                    end
                end
            end
            if (cyc == 20) break;
            drive_cpu(0, 32'h10, 32'h0, 4'hF);
            drive_ldr(0, 32'h8, 32'h0, 4'hF);
            #1;
            exp_ldr = (m == 8);
            tests_run++;
            if (bus.ldr_ready !== exp_ldr || bus.cpu_ready !== !exp_ldr) begin tests_failed++; $display("FAIL starve_grant[%0d] got c=%b l=%b want l=%b", cyc, bus.cpu_ready, bus.ldr_ready, exp_ldr); end
            if (bus.ldr_ready === 1'b1 && first_ldr < 0) first_ldr = cyc;
            if (bus.cpu_ready !== 1'b1) stalls++;
            sb.push_back('{ldr: exp_ldr, data: exp_ldr ? ref_mem[2] : ref_mem[4]});
            m = exp_ldr ? 0 : (m < 8 ? m + 1 : 8);
        end
        set_idle();
        tests_run++; if (first_ldr != 8) begin tests_failed++; $display("FAIL starve_first_ldr got %0d want 8", first_ldr); end
        tests_run++; if (stalls != 2) begin tests_failed++; $display("FAIL starve_cpu_stalls got %0d want 2", stalls); end
`ifdef DMEM_ARB_PERF_EN
        tests_run++; if (bus.perf_cpu_stall - perf0 !== 32'd2) begin tests_failed++; $display("FAIL perf_stall_delta got %0d want 2", bus.perf_cpu_stall - perf0); end
`else
        tests_run++; if (bus.perf_cpu_stall !== 32'd0 || bus.perf_ldr_xfer !== 32'd0 || perf0 !== 32'd0) begin tests_failed++; $display("FAIL perf_tied got %h/%h want 0/0", bus.perf_cpu_stall, bus.perf_ldr_xfer); end
`endif
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive_cpu(0, 32'h10, 32'h0, 4'hF);
        #1;
        tests_run++; if (bus.cpu_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_ready got %b want 1", bus.cpu_ready); end
        // This read's return is dropped by the reset, so nothing goes on the scoreboard.
        @(negedge clk);
        set_idle();
        reset = 1;
        #1;
        tests_run++; if (bus.cpu_rvalid !== 1'b0 || bus.ldr_rvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_rvalid got %b/%b want 0/0", bus.cpu_rvalid, bus.ldr_rvalid); end
        tests_run++; if (bus.cpu_rdata !== 32'h0 || bus.mem_addr !== 10'h0 || bus.mem_en !== 1'b0 || bus.cpu_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_outs got rd=%h addr=%h en=%b rdy=%b want 0", bus.cpu_rdata, bus.mem_addr, bus.mem_en, bus.cpu_ready); end
        @(negedge clk);
        reset = 0;
        #1;
        tests_run++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_after got rv=%b rd=%h want 0/0", bus.cpu_rvalid, bus.cpu_rdata); end
        tests_run++; if (sb.size() != 0) begin tests_failed++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    endtask

    initial begin
        set_idle();
        reset = 1;
        repeat (2) @(negedge clk);
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_out_of_range();
        test_interleaved();
        test_back_to_back();
        test_starvation();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
